// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with dead-time and tear-free double-buffered frame updates
// Optional brightness PWM on the lit digit is enabled by defining SEG_SCAN_BRIGHT_EN.
module seg_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [8*DIGITS-1:0]   seg_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [3:0]            brightness,
`endif
  output logic                  frame_done
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {S_BLANK, S_DISPLAY} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [8*DIGITS-1:0]   r_active;
  logic [8*DIGITS-1:0]   r_shadow;
  logic                  r_pending;

  logic [CW-1:0]         w_cnt_inc;
  logic [DIGITS-1:0]     w_an_sel;
  logic [7:0]            w_seg_sel;
  logic                  w_lit_first;
  logic                  w_lit_next;

  assign upd_ready = !r_pending;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_an_sel  = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
  assign w_seg_sel = r_active[8*r_idx +: 8];

`ifdef SEG_SCAN_BRIGHT_EN
  // Lit window is evaluated against the count the registers will hold after this edge.
  int w_thresh;
  always_comb begin
    w_thresh = ((int'(brightness) + 1) * SCAN_DIV) >> 4;
  end
  assign w_lit_first = (w_thresh > 0);
  assign w_lit_next  = (int'(w_cnt_inc) < w_thresh);
`else
  assign w_lit_first = 1'b1;
  assign w_lit_next  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_active   <= {DIGITS{8'hFF}};
      r_shadow   <= {DIGITS{8'hFF}};
      r_pending  <= 1'b0;
      an         <= '1;
      seg_out    <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (upd_valid && !r_pending) begin
        r_shadow  <= seg_in;
        r_pending <= 1'b1;
      end
      case (r_state)
        S_BLANK: begin
          if (r_cnt == CW'(BLANK_CYC - 1)) begin
            r_state <= S_DISPLAY;
            r_cnt   <= '0;
            if (w_lit_first) begin
              an      <= w_an_sel;
              seg_out <= w_seg_sel;
            end else begin
              an      <= '1;
              seg_out <= 8'hFF;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DISPLAY: begin
          if (r_cnt == CW'(SCAN_DIV - 1)) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            an      <= '1;
            seg_out <= 8'hFF;
            if (r_idx == IW'(DIGITS - 1)) begin
              // Frame boundary: the only point where a buffered frame may go live.
              r_idx      <= '0;
              frame_done <= 1'b1;
              if (r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_lit_next) begin
              an      <= w_an_sel;
              seg_out <= w_seg_sel;
            end else begin
              an      <= '1;
              seg_out <= 8'hFF;
            end
          end
        end
        default: r_state <= S_BLANK;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Physical-side driver for the multiplexed 7-segment display.
- Consumes a packed frame of active-low segment patterns (8 bits per digit, dp in bit 7) from the hex-to-segment encoder.
- Time-multiplexes the frame onto the shared segment bus and per-digit anode lines, with a dead-time between digits to suppress ghosting.
- Double-buffers frame updates through a valid/ready handshake, so a new frame is applied only at a frame boundary and never tears.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 100000, clk cycles a digit stays lit; must be >= 1.
- BLANK_CYC, 16, clk cycles all anodes are off between digits; must be >= 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- upd_valid  input  1  new frame present on seg_in.
- upd_ready  output  1  shadow buffer free; a frame is accepted when upd_valid && upd_ready.
- seg_in  input  8*DIGITS  new frame; digit k occupies [8k+7:8k], active-low segments.
- seg_out  output  8  active-low segment bus {dp,g,f,e,d,c,b,a}.
- an  output  DIGITS  active-low digit enables; at most one bit low at any time.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Storage:
  - active buffer (8*DIGITS bits), drives the display.
  - shadow buffer plus a pending flag.
  - upd_ready = !pending (combinational from the registered flag).
- Handshake:
  - On accept, shadow <= seg_in and pending <= 1.
  - Holding upd_valid while upd_ready = 0 has no effect; seg_in is not sampled.
- FSM states: BLANK, DISPLAY. Registers: cycle counter cnt, digit index idx.
- BLANK:
  - an = all ones, seg_out = 8'hFF.
  - Lasts exactly BLANK_CYC cycles, then goes to DISPLAY with cnt cleared.
- DISPLAY:
  - an[idx] = 0, all other an bits = 1.
  - seg_out = active[8*idx +: 8].
  - Lasts exactly SCAN_DIV cycles, then goes to BLANK.
  - On that exit, idx increments; when idx = DIGITS-1 it wraps to 0.
- Frame boundary = the exit from DISPLAY with idx = DIGITS-1. On that same edge:
  - frame_done <= 1 for one cycle.
  - If pending: active <= shadow and pending <= 0, so upd_ready rises on the next cycle.
- Simultaneous events: an accept cannot coincide with a swap, because upd_ready is low whenever pending is set. One frame is buffered at most; further frames are back-pressured.
- Outputs an, seg_out and frame_done are registered and change on the same edge as the state transition.
- Frame period = DIGITS*(SCAN_DIV+BLANK_CYC) cycles.
- Reset values:
  - state BLANK, cnt 0, idx 0.
  - active = all 8'hFF (every digit dark), pending 0.
  - an = all ones, seg_out = 8'hFF, frame_done 0, upd_ready 1.
- Reset asserted mid-operation restores all reset values on the next edge. Any pending shadow frame is discarded and the scan restarts at BLANK, digit 0.
- Counter width = clog2 of max(SCAN_DIV, BLANK_CYC)+1. No wrap-around inside a phase.

Optional Feature:
- Macro: SEG_SCAN_BRIGHT_EN.
- Defined:
  - Adds input port brightness [3:0].
  - During DISPLAY, an[idx] is driven low only while cnt < ((brightness+1)*SCAN_DIV)>>4. For the rest of DISPLAY, an is all ones and seg_out is 8'hFF.
  - brightness = 15 gives a full-on duty cycle.
  - brightness is sampled each cycle; no buffering.
- Not defined: no brightness port; the digit is lit for the whole DISPLAY phase.

Test Plan (DIGITS=4, SCAN_DIV=4, BLANK_CYC=2 unless stated):
1. Release rst, no updates -> an=4'hF for 2 cycles, then an=4'hE and seg_out=8'hFF for 4 cycles, then blank. frame_done first pulses 24 cycles after reset release; upd_ready=1 throughout.
2. One-cycle upd_valid with seg_in=32'hC0F9A4B0 at cycle 5 -> upd_ready=0 from cycle 6 until the boundary. Next frame shows digits 0..3 = B0, A4, F9, C0 with an = E, D, B, 7 respectively.
3. A second upd_valid held high while pending -> not accepted; it is accepted on the first cycle upd_ready returns to 1, and is displayed one frame later.
4. Assert rst for 1 cycle while DISPLAY digit 2 is active with a frame pending -> an=4'hF and seg_out=8'hFF the next cycle; the pending frame is lost; the scan resumes at digit 0 showing 8'hFF.
5. Run 3 frames -> exactly 3 frame_done pulses spaced 24 cycles apart; never more than one an bit low.
6. With SEG_SCAN_BRIGHT_EN, SCAN_DIV=16, brightness=3 -> each digit is lit 4 of its 16 DISPLAY cycles. brightness=15 -> lit all 16.
